// File: rtl/stream_mux_pkg.sv
// Shared constants for the round-robin stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between N producer streams, the mux and its single consumer.
interface stream_mux_rr_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8
) ();
  localparam int unsigned SELW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_last;
  logic [SELW-1:0]    out_src;
  logic               out_ready;

  // Mux side
  modport slave (
    input  in_data, in_valid, in_last, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_last, out_src
  );

  // Producer/consumer side
  modport master (
    output in_data, in_valid, in_last, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_src
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester after ptr, modulo N.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int unsigned SELW = $clog2(N);

  logic [SELW-1:0] idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = SELW'((32'(ptr) + k) % N);
      if (en && !gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end
endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 stream mux with registered output slot, explicit or round-robin steering.
// Optional packet lock enabled by defining MUX_LOCK_EN.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4
) (
  input logic            clk,
  input logic            rst_n,
  stream_mux_rr_if.slave bus
);
  localparam int unsigned SELW = $clog2(N);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_last_q,  out_last_d;
  logic [SELW-1:0]  out_src_q,   out_src_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic             load_en_c;
  logic             locked_c;
  logic [SELW-1:0]  lock_idx_c;
  logic             rr_valid_c;
  logic [SELW-1:0]  rr_idx_c;
  logic             gnt_valid_c;
  logic [SELW-1:0]  gnt_idx_c;
  logic             xfer_c;
  logic [N-1:0]     in_ready_c;

  rr_arbiter #(.N(N)) u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr_q),
    .en        ((bus.mode == MODE_RR) && !locked_c),
    .gnt_valid (rr_valid_c),
    .gnt_idx   (rr_idx_c)
  );

  // Grant selection: lock overrides mode; out-of-range sel never grants
  always_comb begin
    gnt_valid_c = 1'b0;
    gnt_idx_c   = '0;
    if (locked_c) begin
      gnt_idx_c   = lock_idx_c;
      gnt_valid_c = bus.in_valid[lock_idx_c];
    end else if (bus.mode == MODE_RR) begin
      gnt_idx_c   = rr_idx_c;
      gnt_valid_c = rr_valid_c;
    end else if ({1'b0, bus.sel} < (SELW+1)'(N)) begin
      gnt_idx_c   = bus.sel;
      gnt_valid_c = bus.in_valid[bus.sel];
    end
  end

  assign load_en_c = !out_valid_q || bus.out_ready;
  assign xfer_c    = gnt_valid_c && load_en_c;

  always_comb begin
    in_ready_c = '0;
    if (xfer_c) in_ready_c[gnt_idx_c] = 1'b1;
  end

  // Output slot and round-robin pointer
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (xfer_c) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[32'(gnt_idx_c)*WIDTH +: WIDTH];
      out_last_d  = bus.in_last[gnt_idx_c];
      out_src_d   = gnt_idx_c;
      ptr_d       = gnt_idx_c;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
      ptr_q       <= SELW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef MUX_LOCK_EN
  logic            lock_q,     lock_d;
  logic [SELW-1:0] lock_idx_q, lock_idx_d;

  // Hold the grant on a channel from its first non-last beat until its last beat
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (xfer_c) begin
      lock_d     = !bus.in_last[gnt_idx_c];
      lock_idx_d = gnt_idx_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign locked_c   = lock_q;
  assign lock_idx_c = lock_idx_q;
`else
  assign locked_c   = 1'b0;
  assign lock_idx_c = '0;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: directed stimulus pushes expected beats, a monitor pops them.
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] src;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_mux_rr_if #(.N(N), .WIDTH(WIDTH)) bus ();

  stream_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output beat must match the head of the queue
  initial begin
    forever begin
      beat_t e;
      @(negedge clk);
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got src=%0d data=0x%0h, expected no beat",
                   bus.out_src, bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {21'b0, bus.out_data, bus.out_last, bus.out_src}, {21'b0, e});
        end
      end
    end
  end

  task automatic set_ch(input int i, input logic v, input logic [7:0] d, input logic l);
    bus.in_valid[i]               = v;
    bus.in_data[i*WIDTH +: WIDTH] = d;
    bus.in_last[i]                = l;
  endtask

  task automatic idle_all();
    bus.in_valid = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l, input logic [1:0] s);
    beat_t b;
    b.data = d;
    b.last = l;
    b.src  = s;
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // One cycle of a two-channel script with the grant it must produce
  task automatic script_cycle(input logic v0, input logic [7:0] d0, input logic l0,
                              input logic v1, input logic [7:0] d1, input logic l1,
                              input logic [7:0] ed, input logic el, input logic [1:0] es);
    set_ch(0, v0, d0, l0);
    set_ch(1, v1, d1, l1);
    push(ed, el, es);
    @(negedge clk);
    chk("script_in_ready", 32'(bus.in_ready), 32'(1) << es);
    next_cycle();
  endtask

  logic [1:0] rr13 [4] = '{2'd3, 2'd1, 2'd3, 2'd1};

  initial begin
    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.mode      = MODE_SEL;
    bus.sel       = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_out_src",   32'(bus.out_src),   32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    next_cycle();
    rst_n = 1'b1;

    // Explicit select of channel 2 with all channels valid
    for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 8'(8'h10 + i), 1'b1);
    bus.sel = 2'd2;
    for (int c = 0; c < 4; c++) begin
      push(8'h12, 1'b1, 2'd2);
      @(negedge clk);
      chk("sel_in_ready", 32'(bus.in_ready), 32'b0100);
      if (c == 1) chk("sel_latency", 32'(bus.out_valid), 32'd1);
      next_cycle();
    end
    // Selected channel idle while others valid: no grant
    set_ch(3, 1'b0, 8'h13, 1'b1);
    bus.sel = 2'd3;
    @(negedge clk);
    chk("sel_idle_in_ready", 32'(bus.in_ready), 32'd0);
    next_cycle();
    idle_all();
    repeat (2) next_cycle();

    // Round robin, all channels valid: 0,1,2,3,0,1
    do_reset();
    bus.mode = MODE_RR;
    for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 8'(8'h20 + i), 1'b1);
    for (int c = 0; c < 6; c++) begin
      push(8'(8'h20 + c % 4), 1'b1, 2'(c % 4));
      @(negedge clk);
      chk("rr_in_ready", 32'(bus.in_ready), 32'(1) << (c % 4));
      next_cycle();
    end
    // Only channels 1 and 3 valid; pointer sits at 1 so 3 goes first
    idle_all();
    set_ch(1, 1'b1, 8'h31, 1'b1);
    set_ch(3, 1'b1, 8'h33, 1'b1);
    for (int c = 0; c < 4; c++) begin
      push(8'(8'h30 + rr13[c]), 1'b1, rr13[c]);
      @(negedge clk);
      chk("rr13_in_ready", 32'(bus.in_ready), 32'(1) << rr13[c]);
      next_cycle();
    end
    idle_all();
    repeat (2) next_cycle();

    // Backpressure: beat held for 3 stalled cycles, next beat follows release
    bus.mode      = MODE_SEL;
    bus.sel       = 2'd0;
    bus.out_ready = 1'b0;
    set_ch(0, 1'b1, 8'hA0, 1'b1);
    push(8'hA0, 1'b1, 2'd0);
    next_cycle();
    set_ch(0, 1'b1, 8'hA1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_data",  32'(bus.out_data),  32'hA0);
      chk("bp_out_src",   32'(bus.out_src),   32'd0);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      next_cycle();
    end
    bus.out_ready = 1'b1;
    push(8'hA1, 1'b1, 2'd0);
    @(negedge clk);
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'b0001);
    next_cycle();
    idle_all();
    repeat (2) next_cycle();

    // Packet on channel 0 competing with channel 1
    do_reset();
    bus.mode = MODE_RR;
`ifdef MUX_LOCK_EN
    script_cycle(1'b1, 8'h40, 1'b0, 1'b1, 8'h50, 1'b1, 8'h40, 1'b0, 2'd0);
    script_cycle(1'b1, 8'h41, 1'b0, 1'b1, 8'h50, 1'b1, 8'h41, 1'b0, 2'd0);
    script_cycle(1'b1, 8'h42, 1'b1, 1'b1, 8'h50, 1'b1, 8'h42, 1'b1, 2'd0);
    script_cycle(1'b0, 8'h42, 1'b1, 1'b1, 8'h50, 1'b1, 8'h50, 1'b1, 2'd1);
`else
    script_cycle(1'b1, 8'h40, 1'b0, 1'b1, 8'h50, 1'b1, 8'h40, 1'b0, 2'd0);
    script_cycle(1'b1, 8'h41, 1'b0, 1'b1, 8'h50, 1'b1, 8'h50, 1'b1, 2'd1);
    script_cycle(1'b1, 8'h41, 1'b0, 1'b1, 8'h51, 1'b1, 8'h41, 1'b0, 2'd0);
    script_cycle(1'b1, 8'h42, 1'b1, 1'b1, 8'h51, 1'b1, 8'h51, 1'b1, 2'd1);
`endif
    idle_all();
    repeat (2) next_cycle();

    // Reset while a non-last beat sits in the slot
    bus.mode      = MODE_SEL;
    bus.sel       = 2'd2;
    bus.out_ready = 1'b0;
    set_ch(2, 1'b1, 8'h60, 1'b0);
    push(8'h60, 1'b0, 2'd2);
    next_cycle();
    idle_all();
    @(negedge clk);
    chk("mid_rst_pre_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async_valid", 32'(bus.out_valid), 32'd0);
    exp_q.delete();
    next_cycle();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    bus.mode      = MODE_RR;
    for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 8'(8'h70 + i), 1'b1);
    push(8'h70, 1'b1, 2'd0);
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'b0001);
    next_cycle();
    idle_all();
    repeat (3) next_cycle();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
